// File: rtl/tile_pixel_serializer.sv
// tile_pixel_serializer: two-layer 8-pixel tile serializer with staging, fine scroll and flip.
// Each layer double-buffers tiles (staging -> current -> previous) and tracks under/overrun.
module tps_layer #(
   parameter int COL_W = 8,
   parameter int PIX_W = 4
) (
   input  logic                   clk_24M,
   input  logic                   RES,
   input  logic                   i_ce,
   input  logic                   i_bnd,
   input  logic                   i_load,
   input  logic                   i_flip,
   input  logic                   i_clr,
   input  logic [2:0]             i_ph,
   input  logic [2:0]             i_z,
   input  logic [8*PIX_W-1:0]     i_rom,
   input  logic [COL_W-1:0]       i_col,
   output logic [COL_W+PIX_W-1:0] o_ds,
   output logic                   o_opq,
   output logic                   o_under,
   output logic                   o_ovr
);
   logic [8*PIX_W-1:0] r_stg_rom, r_cur_rom, r_prv_rom;
   logic [COL_W-1:0]   r_stg_col, r_cur_col, r_prv_col;
   logic               r_stg_flip, r_cur_flip, r_prv_flip, r_stg_valid;
   logic [2:0]         r_zl;
   logic               w_use_prv;
   logic [3:0]         w_n;
   logic [2:0]         w_idx;
   logic [PIX_W-1:0]   w_pix;
   // Phases before the scroll offset still show the tail of the previous tile
   always_comb begin
      w_use_prv = i_ph < r_zl;
      w_n       = w_use_prv ? 4'd8 - {1'b0, r_zl} + {1'b0, i_ph} : {1'b0, i_ph} - {1'b0, r_zl};
      w_idx     = (w_use_prv ? r_prv_flip : r_cur_flip) ? 3'd7 - w_n[2:0] : w_n[2:0];
      w_pix     = w_use_prv ? r_prv_rom[PIX_W*w_idx +: PIX_W] : r_cur_rom[PIX_W*w_idx +: PIX_W];
   end
   always_ff @(posedge clk_24M) begin
      if (RES) begin
         r_stg_rom   <= '0;
         r_stg_col   <= '0;
         r_stg_flip  <= 1'b0;
         r_stg_valid <= 1'b0;
         r_cur_rom   <= '0;
         r_cur_col   <= '0;
         r_cur_flip  <= 1'b0;
         r_prv_rom   <= '0;
         r_prv_col   <= '0;
         r_prv_flip  <= 1'b0;
         r_zl        <= 3'd0;
         o_ds        <= '0;
         o_opq       <= 1'b0;
         o_under     <= 1'b0;
         o_ovr       <= 1'b0;
      end else begin
         if (i_bnd) begin
            r_prv_rom  <= r_cur_rom;
            r_prv_col  <= r_cur_col;
            r_prv_flip <= r_cur_flip;
            r_zl       <= i_z;
            r_cur_rom  <= r_stg_valid ? r_stg_rom : '0;
            r_cur_col  <= r_stg_valid ? r_stg_col : '0;
            r_cur_flip <= r_stg_valid & r_stg_flip;
         end
         if (i_load) begin
            r_stg_rom  <= i_rom;
            r_stg_col  <= i_col;
            r_stg_flip <= i_flip;
         end
         r_stg_valid <= i_load | (r_stg_valid & ~i_bnd);
         if (i_ce) begin
            o_ds  <= {w_use_prv ? r_prv_col : r_cur_col, w_pix};
            o_opq <= |w_pix;
         end
         o_under <= (i_bnd & ~r_stg_valid) | (o_under & ~i_clr);
         o_ovr   <= (i_load & r_stg_valid & ~i_bnd) | (o_ovr & ~i_clr);
      end
   end
endmodule

module tile_pixel_serializer #(
   parameter int COL_W = 8,
   parameter int PIX_W = 4
) (
   input  logic                   clk_24M,
   input  logic                   RES,
   input  logic                   PIX_CE,
   input  logic                   LOAD_A,
   input  logic                   LOAD_B,
   input  logic [8*PIX_W-1:0]     ROM_A,
   input  logic [8*PIX_W-1:0]     ROM_B,
   input  logic [COL_W-1:0]       COL_A,
   input  logic [COL_W-1:0]       COL_B,
   input  logic                   HFLIP_A,
   input  logic                   HFLIP_B,
   input  logic [2:0]             ZA,
   input  logic [2:0]             ZB,
   input  logic                   FLAG_CLR,
   output logic [COL_W+PIX_W-1:0] DSA,
   output logic [COL_W+PIX_W-1:0] DSB,
   output logic                   OPQ_A,
   output logic                   OPQ_B,
   output logic [2:0]             PH,
   output logic                   UNDER_A,
   output logic                   UNDER_B,
   output logic                   OVR_A,
   output logic                   OVR_B
);
   logic [2:0] r_ph;
   logic       w_bnd;
   assign w_bnd = PIX_CE & (r_ph == 3'd7);
   assign PH    = r_ph;
   always_ff @(posedge clk_24M) begin
      if (RES) r_ph <= 3'd0;
      else if (PIX_CE) r_ph <= r_ph + 3'd1;
   end
   tps_layer #(.COL_W(COL_W), .PIX_W(PIX_W)) u_a (
      .clk_24M(clk_24M), .RES(RES), .i_ce(PIX_CE), .i_bnd(w_bnd), .i_load(LOAD_A),
      .i_flip(HFLIP_A), .i_clr(FLAG_CLR), .i_ph(r_ph), .i_z(ZA), .i_rom(ROM_A), .i_col(COL_A),
      .o_ds(DSA), .o_opq(OPQ_A), .o_under(UNDER_A), .o_ovr(OVR_A)
   );
   tps_layer #(.COL_W(COL_W), .PIX_W(PIX_W)) u_b (
      .clk_24M(clk_24M), .RES(RES), .i_ce(PIX_CE), .i_bnd(w_bnd), .i_load(LOAD_B),
      .i_flip(HFLIP_B), .i_clr(FLAG_CLR), .i_ph(r_ph), .i_z(ZB), .i_rom(ROM_B), .i_col(COL_B),
      .o_ds(DSB), .o_opq(OPQ_B), .o_under(UNDER_B), .o_ovr(OVR_B)
   );
endmodule

// File: tb/tb_tile_pixel_serializer.sv
// tb_tile_pixel_serializer: directed scenarios for the two-layer tile serializer.
module tb_tile_pixel_serializer;
   logic        clk_24M = 1'b0, RES = 1'b0, PIX_CE = 1'b0, LOAD_A = 1'b0, LOAD_B = 1'b0;
   logic [31:0] ROM_A = '0, ROM_B = '0;
   logic [7:0]  COL_A = '0, COL_B = '0;
   logic        HFLIP_A = 1'b0, HFLIP_B = 1'b0, FLAG_CLR = 1'b0;
   logic [2:0]  ZA = '0, ZB = '0;
   logic [11:0] DSA, DSB;
   logic        OPQ_A, OPQ_B, UNDER_A, UNDER_B, OVR_A, OVR_B;
   logic [2:0]  PH;
   int          total = 0, bad = 0;
   logic [11:0] e;

   tile_pixel_serializer dut (
      .clk_24M(clk_24M), .RES(RES), .PIX_CE(PIX_CE), .LOAD_A(LOAD_A), .LOAD_B(LOAD_B),
      .ROM_A(ROM_A), .ROM_B(ROM_B), .COL_A(COL_A), .COL_B(COL_B), .HFLIP_A(HFLIP_A),
      .HFLIP_B(HFLIP_B), .ZA(ZA), .ZB(ZB), .FLAG_CLR(FLAG_CLR), .DSA(DSA), .DSB(DSB),
      .OPQ_A(OPQ_A), .OPQ_B(OPQ_B), .PH(PH), .UNDER_A(UNDER_A), .UNDER_B(UNDER_B),
      .OVR_A(OVR_A), .OVR_B(OVR_B)
   );

   always #10 clk_24M = ~clk_24M;

   initial begin
      #1000000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk_24M);
      #1;
   endtask

   task automatic load_a(input logic [31:0] rom, input logic [7:0] col, input logic flip);
      LOAD_A = 1'b1; ROM_A = rom; COL_A = col; HFLIP_A = flip;
      step();
      LOAD_A = 1'b0;
   endtask

   task automatic pix();
      PIX_CE = 1'b1;
      step();
      PIX_CE = 1'b0;
   endtask

   task automatic test_reset();
      RES = 1'b1; PIX_CE = 1'b1; LOAD_A = 1'b1; ROM_A = 32'hFFFFFFFF;
      step();
      RES = 1'b0; PIX_CE = 1'b0; LOAD_A = 1'b0;
      total++; if (PH !== 3'd0) begin bad++; $display("FAIL reset_ph got=%0d exp=0", PH); end
      total++; if ({DSA, DSB} !== 24'h0) begin bad++; $display("FAIL reset_ds got=%h/%h exp=0", DSA, DSB); end
      total++; if ({OPQ_A, OPQ_B, UNDER_A, UNDER_B, OVR_A, OVR_B} !== 6'b0)
         begin bad++; $display("FAIL reset_flags got=%b exp=000000", {OPQ_A, OPQ_B, UNDER_A, UNDER_B, OVR_A, OVR_B}); end
   endtask

   task automatic test_normal();
      load_a(32'h87654321, 8'h5A, 1'b0);
      for (int k = 0; k < 8; k++) begin
         pix();
         total++; if (PH !== 3'((k + 1) % 8)) begin bad++; $display("FAIL ph_inc k=%0d got=%0d exp=%0d", k, PH, (k + 1) % 8); end
         total++; if (DSA !== 12'h0 || OPQ_A !== 1'b0) begin bad++; $display("FAIL transparent k=%0d got=%h/%b exp=000/0", k, DSA, OPQ_A); end
      end
      total++; if (UNDER_A !== 1'b0) begin bad++; $display("FAIL under_a_clean got=%b exp=0", UNDER_A); end
      total++; if (UNDER_B !== 1'b1) begin bad++; $display("FAIL under_b_set got=%b exp=1", UNDER_B); end
      load_a(32'h87654321, 8'h5A, 1'b1);
      for (int k = 0; k < 8; k++) begin
         pix();
         e = {8'h5A, 4'(k + 1)};
         total++; if (DSA !== e || OPQ_A !== 1'b1) begin bad++; $display("FAIL normal k=%0d got=%h/%b exp=%h/1", k, DSA, OPQ_A, e); end
         total++; if (DSB !== 12'h0 || OPQ_B !== 1'b0 || UNDER_B !== 1'b1)
            begin bad++; $display("FAIL b_empty k=%0d got=%h/%b/%b exp=000/0/1", k, DSB, OPQ_B, UNDER_B); end
      end
      total++; if (UNDER_A !== 1'b0 || OVR_A !== 1'b0) begin bad++; $display("FAIL normal_flags got=%b%b exp=00", UNDER_A, OVR_A); end
   endtask

   task automatic test_hflip();
      load_a(32'h11111111, 8'h01, 1'b0);
      for (int k = 0; k < 8; k++) begin
         pix();
         e = {8'h5A, 4'(8 - k)};
         total++; if (DSA !== e) begin bad++; $display("FAIL hflip k=%0d got=%h exp=%h", k, DSA, e); end
      end
   endtask

   task automatic test_scroll();
      ZA = 3'd3;
      load_a(32'h22222222, 8'h02, 1'b0);
      for (int k = 0; k < 8; k++) begin
         pix();
         total++; if (DSA !== 12'h011) begin bad++; $display("FAIL tile1 k=%0d got=%h exp=011", k, DSA); end
      end
      load_a(32'hAAAAAAAA, 8'h0A, 1'b0);
      total++; if (OVR_A !== 1'b0) begin bad++; $display("FAIL ovr_first got=%b exp=0", OVR_A); end
      load_a(32'hBBBBBBBB, 8'h07, 1'b0);
      total++; if (OVR_A !== 1'b1) begin bad++; $display("FAIL ovr_second got=%b exp=1", OVR_A); end
      ZA = 3'd0;
      for (int k = 0; k < 8; k++) begin
         pix();
         e = (k < 3) ? 12'h011 : 12'h022;
         total++; if (DSA !== e) begin bad++; $display("FAIL scroll k=%0d got=%h exp=%h", k, DSA, e); end
      end
   endtask

   task automatic test_coincident();
      for (int k = 0; k < 8; k++) begin
         if (k == 7) begin LOAD_A = 1'b1; ROM_A = 32'hCCCCCCCC; COL_A = 8'h0C; HFLIP_A = 1'b0; end
         pix();
         LOAD_A = 1'b0;
         total++; if (DSA !== 12'h07B) begin bad++; $display("FAIL ovr_tile k=%0d got=%h exp=07B", k, DSA); end
      end
      total++; if (UNDER_A !== 1'b1 || OVR_A !== 1'b1) begin bad++; $display("FAIL coinc_flags got=%b%b exp=11", UNDER_A, OVR_A); end
      for (int k = 0; k < 8; k++) begin
         pix();
         total++; if (DSA !== 12'h0 || OPQ_A !== 1'b0) begin bad++; $display("FAIL under_tile k=%0d got=%h/%b exp=000/0", k, DSA, OPQ_A); end
      end
      load_a(32'hDDDDDDDD, 8'h0D, 1'b0);
      total++; if (OVR_A !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b exp=1", OVR_A); end
      for (int k = 0; k < 8; k++) begin
         pix();
         total++; if (DSA !== 12'h0CC) begin bad++; $display("FAIL late_tile k=%0d got=%h exp=0CC", k, DSA); end
      end
   endtask

   task automatic test_flag_clr();
      total++; if (UNDER_B !== 1'b1) begin bad++; $display("FAIL under_b_hold got=%b exp=1", UNDER_B); end
      FLAG_CLR = 1'b1;
      step();
      FLAG_CLR = 1'b0;
      total++; if ({UNDER_A, UNDER_B, OVR_A} !== 3'b000) begin bad++; $display("FAIL flag_clr got=%b exp=000", {UNDER_A, UNDER_B, OVR_A}); end
      load_a(32'hEEEEEEEE, 8'h0E, 1'b0);
      for (int k = 0; k < 8; k++) begin
         if (k == 7) FLAG_CLR = 1'b1;
         pix();
         FLAG_CLR = 1'b0;
         total++; if (DSA !== 12'h0DD) begin bad++; $display("FAIL tile6 k=%0d got=%h exp=0DD", k, DSA); end
      end
      total++; if (UNDER_B !== 1'b1 || UNDER_A !== 1'b0) begin bad++; $display("FAIL set_wins got=%b%b exp=10", UNDER_B, UNDER_A); end
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 4; k++) pix();
      load_a(32'h12345678, 8'h0F, 1'b0);
      load_a(32'h12345678, 8'h0F, 1'b0);
      step();
      total++; if (PH !== 3'd4 || DSA !== 12'h0EE) begin bad++; $display("FAIL ph_hold got=%0d/%h exp=4/0EE", PH, DSA); end
      total++; if (OVR_A !== 1'b1) begin bad++; $display("FAIL ovr_pre_reset got=%b exp=1", OVR_A); end
      RES = 1'b1; PIX_CE = 1'b1; LOAD_A = 1'b1; FLAG_CLR = 1'b0;
      step();
      RES = 1'b0; PIX_CE = 1'b0; LOAD_A = 1'b0;
      total++; if (PH !== 3'd0 || DSA !== 12'h0 || DSB !== 12'h0)
         begin bad++; $display("FAIL reset_mid got=%0d/%h/%h exp=0/000/000", PH, DSA, DSB); end
      total++; if ({OPQ_A, OPQ_B, UNDER_A, UNDER_B, OVR_A, OVR_B} !== 6'b0)
         begin bad++; $display("FAIL reset_mid_flags got=%b exp=000000", {OPQ_A, OPQ_B, UNDER_A, UNDER_B, OVR_A, OVR_B}); end
      pix();
      total++; if (PH !== 3'd1 || DSA !== 12'h0) begin bad++; $display("FAIL post_reset got=%0d/%h exp=1/000", PH, DSA); end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_hflip();
      test_scroll();
      test_coincident();
      test_flag_clr();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
